set_score_screen: RTL and testbench
===================================

# set_score_screen

Parametrised, stateful successor to the set-score overlay for the pong game. It draws the "SET SCORE" title and an N-digit decimal target score. It also owns the score-edit interaction: up/down with auto-repeat, clamping, and a confirm/acknowledge handshake that hands the chosen target score to the game controller. It sits between the debounced button inputs, the VGA pixel scanner (x, y) and the game FSM.

## Interface
Parameters:
- SCORE_W, 5: width of score value.
- MIN_SCORE, 1: lowest selectable score.
- MAX_SCORE, 21: highest selectable score; must be ≤ 2^SCORE_W−1 and ≤ 10^DIGITS−1.
- DEFAULT_SCORE, 5: value loaded on entry to edit.
- DIGITS, 2: decimal digits rendered.
- TITLE_X, 183 / TITLE_Y, 140: title origin. DIGIT_X, 291 / DIGIT_Y, 240: first-digit origin.
- CHAR_PITCH, 31: horizontal pixel pitch between glyphs.
- REPEAT_DELAY, 30: frames a button is held before auto-repeat starts.
- REPEAT_RATE, 6: frames between repeats.
- BLINK_FRAMES, 20: frames per blink half-period.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous, active-low reset.
- active, in, 1: set-score screen selected by the game FSM.
- frame_tick, in, 1: one-cycle pulse per video frame.
- btn_up, btn_down, btn_confirm, in, 1 each: debounced level inputs.
- x, y, in, 10 each: current pixel coordinate.
- score, out, SCORE_W: current or selected target score.
- score_valid, out, 1: offered score is stable.
- score_ack, in, 1: controller accepts the score.
- display, out, 1: pixel is lit.

## Operation
- FSM states: IDLE, EDIT, OFFER, DONE.
- IDLE: display=0, score_valid=0. Rising edge of active → EDIT, score←DEFAULT_SCORE.
- EDIT:
  - Rising edge of btn_up → score+1, saturating at MAX_SCORE. Rising edge of btn_down → score−1, saturating at MIN_SCORE. No wrap-around.
  - Auto-repeat: while exactly one of up/down is held, a per-frame hold counter runs. The first repeat step occurs at REPEAT_DELAY frames, then one step every REPEAT_RATE frames.
  - Both buttons held, or both rising in the same cycle: no change, hold counter cleared.
  - Rising edge of btn_confirm → OFFER. Confirm takes priority over up/down in the same cycle.
- OFFER: score_valid=1, score frozen, buttons ignored. A cycle with score_ack=1 → DONE.
- DONE: score_valid=0, score held, title and digits shown steadily. Buttons ignored.
- active=0 in any state → IDLE on the next edge; score_valid drops and score is retained.
- Button edges are detected against registered previous levels. These registers reset to 0, so a button held through reset does not produce an edge.
- Rendering:
  - Title "SET SCORE" is drawn as 9 glyph slots at CHAR_PITCH; slot 3 is a space.
  - Digits are drawn most-significant first at DIGIT_X + i·CHAR_PITCH, using the 7-segment glyph style.
  - Leading zeros are blanked; the least-significant digit is always drawn.
  - display = title OR digits, valid in EDIT, OFFER and DONE.

## Timing
- display is registered: 1-cycle latency from x/y.
- score updates on the clock edge after the button edge. score_valid rises 1 cycle after the confirm edge.
- score_ack while score_valid=1 → score_valid=0 on the next cycle. score_ack outside OFFER is ignored.
- Reset values: state IDLE, score=DEFAULT_SCORE, score_valid=0, display=0, all counters 0.
- rst_n asserted mid-handshake aborts immediately; the controller must treat this as no offer.

## Configuration
- SET_SCORE_BLINK_EN defined:
  - In EDIT, digits are blanked during alternate BLINK_FRAMES half-periods.
  - The blink phase restarts in the visible half on any score change.
  - The title never blinks.
- Undefined: digits are always visible and the blink counter is not built.

## Structure
- Shared package pong_pkg holds:
  - CHAR_W and CHAR_H glyph dimensions.
  - The set_score_state_t enum.
  - Glyph index constants for S, E, T, C, O, R.
- One sub-module, score_to_digits: combinational binary-to-BCD conversion of SCORE_W bits into DIGITS nibbles, plus leading-zero blank flags.

## Test plan
- Reset, raise active → score=5, score_valid=0. Pixel (291,240) shows the blanked tens digit; the ones digit '5' appears at x=322 one cycle after x/y.
- 20 single up presses from 5 → score saturates at 21. Further presses keep 21. Symmetric down test saturates at 1.
- Hold btn_up from 5 for 30+6·3 frame_ticks → 5 at delay start, 6 at frame 30, then 7, 8, 9 at frames 36, 42, 48.
- Up and down rising in the same cycle → score unchanged, hold counter 0.
- Confirm at 12 → score_valid=1 next cycle, up presses ignored. score_ack → score_valid=0 next cycle, DONE, score=12. Drop active → display=0, IDLE.
- SET_SCORE_BLINK_EN defined: digits dark for frames 20–39 in EDIT. An up press at frame 25 makes digits visible immediately. In DONE, digits are steady.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the pong overlays.
//   CHAR_W/CHAR_H : glyph box in pixels (5x7 bitmap scaled by 4)
//   SEG_T         : stroke thickness of the 7-segment digits
//   set_score_state_t, glyph indices, bitmap / segment lookup helpers.
package pong_pkg;
  localparam int CHAR_W = 20;
  localparam int CHAR_H = 28;
  localparam int SEG_T  = 4;

  typedef enum logic [1:0] {IDLE, EDIT, OFFER, DONE} set_score_state_t;

  localparam logic [2:0] GLYPH_S     = 3'd0;
  localparam logic [2:0] GLYPH_E     = 3'd1;
  localparam logic [2:0] GLYPH_T     = 3'd2;
  localparam logic [2:0] GLYPH_C     = 3'd3;
  localparam logic [2:0] GLYPH_O     = 3'd4;
  localparam logic [2:0] GLYPH_R     = 3'd5;
  localparam logic [2:0] GLYPH_SPACE = 3'd7;

  // "SET SCORE", slot 3 is the space
  function automatic logic [2:0] title_glyph(input int s);
    case (s)
      0, 4:    return GLYPH_S;
      1, 8:    return GLYPH_E;
      2:       return GLYPH_T;
      5:       return GLYPH_C;
      6:       return GLYPH_O;
      7:       return GLYPH_R;
      default: return GLYPH_SPACE;
    endcase
  endfunction

  // 5x7 bitmaps, row 0 first, column 0 is the MSB of each row
  function automatic logic glyph_px(input logic [2:0] idx, input int col, input int row);
    logic [34:0] bm;
    logic [5:0]  bi;
    case (idx)
      GLYPH_S: bm = {5'b01111, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b11110};
      GLYPH_E: bm = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111};
      GLYPH_T: bm = {5'b11111, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
      GLYPH_C: bm = {5'b01111, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b01111};
      GLYPH_O: bm = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
      GLYPH_R: bm = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10100, 5'b10010, 5'b10001};
      default: bm = '0;
    endcase
    if (col < 0 || col > 4 || row < 0 || row > 6) return 1'b0;
    bi = 6'(34 - (row * 5 + col));
    return bm[bi];
  endfunction

  // segments {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // dx/dy are already known to lie inside the glyph box
  function automatic logic seg_px(input logic [6:0] s, input int dx, input int dy);
    logic top, bot, mid, lft, rgt, upr;
    top = dy < SEG_T;
    bot = dy >= CHAR_H - SEG_T;
    mid = (dy >= CHAR_H/2 - SEG_T/2) && (dy < CHAR_H/2 + SEG_T/2);
    lft = dx < SEG_T;
    rgt = dx >= CHAR_W - SEG_T;
    upr = dy < CHAR_H/2;
    return (s[6] & top) | (s[5] & rgt & upr) | (s[4] & rgt & ~upr) | (s[3] & bot) |
           (s[2] & lft & ~upr) | (s[1] & lft & upr) | (s[0] & mid);
  endfunction
endpackage

// File: rtl/score_to_digits.sv
// score_to_digits: combinational binary -> BCD.
//   i_score : binary score
//   o_bcd   : DIGITS nibbles, index 0 = least significant
//   o_blank : leading-zero flags (index 0 never blanked)
module score_to_digits #(
  parameter int SCORE_W = 5,
  parameter int DIGITS  = 2
) (
  input  logic [SCORE_W-1:0]      i_score,
  output logic [DIGITS-1:0][3:0]  o_bcd,
  output logic [DIGITS-1:0]       o_blank
);
  always_comb begin : conv
    int v, p;
    v = int'(i_score);
    p = 1;
    o_bcd   = '0;
    o_blank = '0;
    for (int i = 0; i < DIGITS; i++) begin
      o_bcd[i]   = 4'((v / p) % 10);
      o_blank[i] = (i != 0) && (v < p);
      p = p * 10;
    end
  end
endmodule

// File: rtl/set_score_screen.sv
// set_score_screen: "SET SCORE" overlay plus target-score editor.
//   clk, rst_n          : clock, async active-low reset
//   active              : screen selected by game FSM
//   frame_tick          : one pulse per frame (auto-repeat / blink timebase)
//   btn_up/down/confirm : debounced levels
//   x, y                : scan position; display is lit one cycle later
//   score, score_valid  : offered score, held valid until score_ack
//   score_ack           : controller accepts the offer
// Optional: SET_SCORE_BLINK_EN blinks the digits while editing.
module set_score_screen
  import pong_pkg::*;
#(
  parameter int SCORE_W       = 5,
  parameter int MIN_SCORE     = 1,
  parameter int MAX_SCORE     = 21,
  parameter int DEFAULT_SCORE = 5,
  parameter int DIGITS        = 2,
  parameter int TITLE_X       = 183,
  parameter int TITLE_Y       = 140,
  parameter int DIGIT_X       = 291,
  parameter int DIGIT_Y       = 240,
  parameter int CHAR_PITCH    = 31,
  parameter int REPEAT_DELAY  = 30,
  parameter int REPEAT_RATE   = 6,
  parameter int BLINK_FRAMES  = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               active,
  input  logic               frame_tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_confirm,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic [SCORE_W-1:0] score,
  output logic               score_valid,
  input  logic               score_ack,
  output logic               display
);
  localparam int HC_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [SCORE_W-1:0] L_MIN = SCORE_W'(MIN_SCORE);
  localparam logic [SCORE_W-1:0] L_MAX = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] L_DEF = SCORE_W'(DEFAULT_SCORE);

  set_score_state_t    r_state, w_state_nxt;
  logic [SCORE_W-1:0]  r_score, w_score_nxt;
  logic [HC_W-1:0]     r_hold_cnt, w_hold_nxt;
  logic                r_up_q, r_dn_q, r_cf_q, r_act_q, r_display;
  logic                w_up_rise, w_dn_rise, w_cf_rise, w_act_rise, w_step;
  logic                w_title_hit, w_digit_hit, w_digits_on;
  logic [DIGITS-1:0][3:0] w_bcd;
  logic [DIGITS-1:0]      w_blank;

  assign w_up_rise  = btn_up      & ~r_up_q;
  assign w_dn_rise  = btn_down    & ~r_dn_q;
  assign w_cf_rise  = btn_confirm & ~r_cf_q;
  assign w_act_rise = active      & ~r_act_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_score    <= L_DEF;
      r_hold_cnt <= '0;
      r_up_q     <= 1'b0;
      r_dn_q     <= 1'b0;
      r_cf_q     <= 1'b0;
      r_act_q    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_score    <= w_score_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_up_q     <= btn_up;
      r_dn_q     <= btn_down;
      r_cf_q     <= btn_confirm;
      r_act_q    <= active;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_score_nxt = r_score;
    w_hold_nxt  = '0;
    w_step      = 1'b0;
    if (!active) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_act_rise) begin
          w_state_nxt = EDIT;
          w_score_nxt = L_DEF;
        end
        EDIT: begin
          if (w_cf_rise) begin
            w_state_nxt = OFFER;
          end else if (btn_up ^ btn_down) begin
            // a fresh press steps once and restarts hold timing; after the
            // first repeat the counter reloads so the next fires RATE frames on
            if (w_up_rise | w_dn_rise) begin
              w_step = 1'b1;
            end else if (frame_tick) begin
              if (r_hold_cnt == HC_W'(REPEAT_DELAY - 1)) begin
                w_step     = 1'b1;
                w_hold_nxt = HC_W'(REPEAT_DELAY - REPEAT_RATE);
              end else begin
                w_hold_nxt = r_hold_cnt + 1'b1;
              end
            end else begin
              w_hold_nxt = r_hold_cnt;
            end
          end
          if (w_step) begin
            if (btn_up) w_score_nxt = (r_score >= L_MAX) ? L_MAX : r_score + 1'b1;
            else        w_score_nxt = (r_score <= L_MIN) ? L_MIN : r_score - 1'b1;
          end
        end
        OFFER: if (score_ack) w_state_nxt = DONE;
        default: ;
      endcase
    end
  end

  score_to_digits #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) u_digits (
    .i_score (r_score),
    .o_bcd   (w_bcd),
    .o_blank (w_blank)
  );

`ifdef SET_SCORE_BLINK_EN
  localparam int BL_W = $clog2(BLINK_FRAMES + 1);
  logic [BL_W-1:0] r_blink_cnt;
  logic            r_blink_ph;

  // phase 0 = visible; any score change restarts in the visible half
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (r_state != EDIT || w_score_nxt != r_score) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (frame_tick) begin
      if (r_blink_cnt == BL_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end
  assign w_digits_on = (r_state != EDIT) || !r_blink_ph;
`else
  assign w_digits_on = 1'b1;
`endif

  always_comb begin : render
    int dx, dy, k;
    dx = 0;
    dy = 0;
    k  = 0;
    w_title_hit = 1'b0;
    w_digit_hit = 1'b0;
    dy = int'(y) - TITLE_Y;
    for (int s = 0; s < 9; s++) begin
      dx = int'(x) - (TITLE_X + s * CHAR_PITCH);
      if (dx >= 0 && dx < CHAR_W && dy >= 0 && dy < CHAR_H)
        w_title_hit = w_title_hit | glyph_px(title_glyph(s), dx / 4, dy / 4);
    end
    dy = int'(y) - DIGIT_Y;
    for (int i = 0; i < DIGITS; i++) begin
      k  = DIGITS - 1 - i;  // leftmost slot is the most significant digit
      dx = int'(x) - (DIGIT_X + i * CHAR_PITCH);
      if (dx >= 0 && dx < CHAR_W && dy >= 0 && dy < CHAR_H && !w_blank[k])
        w_digit_hit = w_digit_hit | seg_px(seg7(w_bcd[k]), dx, dy);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_display <= 1'b0;
    else        r_display <= (r_state != IDLE) && (w_title_hit || (w_digit_hit && w_digits_on));
  end

  assign score       = r_score;
  assign score_valid = (r_state == OFFER);
  assign display     = r_display;
endmodule

// File: tb/tb_set_score_screen.sv
module tb_set_score_screen;
  logic       clk = 1'b0, rst_n = 1'b0, active = 1'b0, frame_tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_confirm = 1'b0, score_ack = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic [4:0] score;
  logic       score_valid, display;

  set_score_screen dut (
    .clk(clk), .rst_n(rst_n), .active(active), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_confirm(btn_confirm),
    .x(x), .y(y), .score(score), .score_valid(score_valid),
    .score_ack(score_ack), .display(display)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_SCORE = 0, S_VALID = 1, S_DISP = 2;
  typedef struct { string name; int sel; int exp; int when; } exp_t;
  exp_t q[$];
  int   offq[$];
  int   n_vec = 0, n_bad = 0;

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_now(input string nm, input int sel, input int e);
    exp_t t;
    t.name = nm; t.sel = sel; t.exp = e; t.when = cyc;
    q.push_back(t);
  endtask

  task automatic press_up();   btn_up = 1'b1;   step(); btn_up = 1'b0;   step(); endtask
  task automatic press_down(); btn_down = 1'b1; step(); btn_down = 1'b0; step(); endtask
  task automatic frame();      frame_tick = 1'b1; step(); frame_tick = 1'b0; step(); endtask

  task automatic pix(input string nm, input int px, input int py, input int e);
    x = 10'(px); y = 10'(py);
    step();
    expect_now(nm, S_DISP, e);
  endtask

  // monitor: drains due expectations each falling edge; every rising
  // score_valid is matched against the next expected offer
  initial begin : mon
    logic pv;
    exp_t t;
    int   act, eo;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].when <= cyc) begin
        t = q.pop_front();
        case (t.sel)
          S_SCORE: act = int'(score);
          S_VALID: act = int'(score_valid);
          default: act = int'(display);
        endcase
        n_vec++;
        if (act != t.exp) begin
          n_bad++;
          $display("FAIL %s: got %0d expected %0d", t.name, act, t.exp);
        end
      end
      if (score_valid && !pv) begin
        n_vec++;
        if (offq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_offer: score %0d offered, none expected", score);
        end else begin
          eo = offq.pop_front();
          if (int'(score) != eo) begin
            n_bad++;
            $display("FAIL offer_score: got %0d expected %0d", score, eo);
          end
        end
      end
      pv = score_valid;
    end
  end

  initial begin
    step(2);
    expect_now("rst_score", S_SCORE, 5);
    expect_now("rst_valid", S_VALID, 0);
    expect_now("rst_disp",  S_DISP,  0);
    step();
    rst_n = 1'b1;
    step();

    active = 1'b1;
    step();
    expect_now("entry_score", S_SCORE, 5);
    expect_now("entry_valid", S_VALID, 0);

    pix("tens_blank",   291, 240, 0);
    pix("ones5_a",      322, 240, 1);
    pix("ones5_g",      332, 253, 1);
    pix("ones5_hole",   332, 260, 0);
    pix("ones5_no_b",   341, 245, 0);
    pix("title_S",      187, 140, 1);
    pix("title_S_corner", 183, 140, 0);
    pix("title_T",      255, 160, 1);
    pix("title_space",  280, 150, 0);

    for (int k = 1; k <= 20; k++) begin
      press_up();
      expect_now("up_sat", S_SCORE, (5 + k > 21) ? 21 : 5 + k);
    end
    pix("tens2", 291, 240, 1);
    for (int k = 1; k <= 25; k++) begin
      press_down();
      expect_now("down_sat", S_SCORE, (21 - k < 1) ? 1 : 21 - k);
    end
    pix("ones1_left",   322, 240, 0);
    pix("ones1_b",      341, 240, 1);
    pix("tens_blank_1", 291, 240, 0);

    active = 1'b0;
    step(2);
    expect_now("idle_disp",  S_DISP,  0);
    expect_now("idle_valid", S_VALID, 0);
    expect_now("idle_keep",  S_SCORE, 1);

    // held before entry: no edge, only auto-repeat steps
    btn_up = 1'b1;
    step(2);
    active = 1'b1;
    step();
    expect_now("hold_entry", S_SCORE, 5);
    for (int f = 1; f <= 48; f++) begin
      frame();
      case (f)
        29: expect_now("hold_f29", S_SCORE, 5);
        30: expect_now("hold_f30", S_SCORE, 6);
        35: expect_now("hold_f35", S_SCORE, 6);
        36: expect_now("hold_f36", S_SCORE, 7);
        41: expect_now("hold_f41", S_SCORE, 7);
        42: expect_now("hold_f42", S_SCORE, 8);
        47: expect_now("hold_f47", S_SCORE, 8);
        48: expect_now("hold_f48", S_SCORE, 9);
        default: ;
      endcase
    end
    btn_up = 1'b0;
    step();

    btn_up = 1'b1; btn_down = 1'b1;
    step();
    expect_now("both_rise", S_SCORE, 9);
    repeat (40) frame();
    expect_now("both_held", S_SCORE, 9);
    btn_down = 1'b0;
    repeat (29) frame();
    expect_now("hold_restart_29", S_SCORE, 9);
    frame();
    expect_now("hold_restart_30", S_SCORE, 10);
    btn_up = 1'b0;
    step();

    score_ack = 1'b1;
    step();
    score_ack = 1'b0;
    expect_now("ack_in_edit", S_VALID, 0);
    press_up();
    press_up();
    expect_now("edit_12", S_SCORE, 12);

    btn_up = 1'b1; btn_confirm = 1'b1;
    offq.push_back(12);
    step();
    expect_now("offer_valid",      S_VALID, 1);
    expect_now("confirm_priority", S_SCORE, 12);
    btn_up = 1'b0; btn_confirm = 1'b0;
    step();
    press_up();
    expect_now("offer_frozen", S_SCORE, 12);
    expect_now("offer_hold",   S_VALID, 1);

    score_ack = 1'b1;
    step();
    score_ack = 1'b0;
    expect_now("ack_drop",   S_VALID, 0);
    expect_now("done_score", S_SCORE, 12);
    pix("done_digit", 322, 240, 1);
    press_down();
    expect_now("done_frozen", S_SCORE, 12);

    active = 1'b0;
    step(2);
    expect_now("exit_disp",  S_DISP,  0);
    expect_now("exit_valid", S_VALID, 0);
    expect_now("exit_score", S_SCORE, 12);

    active = 1'b1;
    step();
    expect_now("reentry", S_SCORE, 5);
    btn_confirm = 1'b1;
    offq.push_back(5);
    step();
    btn_confirm = 1'b0;
    expect_now("reoffer", S_VALID, 1);
    step();
    rst_n = 1'b0;
    expect_now("rst_abort_valid", S_VALID, 0);
    expect_now("rst_abort_score", S_SCORE, 5);
    step();
    rst_n = 1'b1;
    step(3);

    if (q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL pending_checks: got %0d left expected 0", q.size());
    end
    if (offq.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL missing_offer: got %0d unseen expected 0", offq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
